mul_q10_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared, pipelined Q10 fixed-point multiplier.
- Lets several datapath blocks (FIR taps, demodulator, de-emphasis, gain) share a single 32x32 signed multiply with dequantize.
- Accepts at most one operand pair per cycle and returns each result to the requester that issued it, in issue order, after a fixed latency.

---
 rtl/mul_q10_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_mul_q10_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_q10_arbiter.sv
// rtl/mul_q10_arbiter.sv - round-robin arbiter and sequencer for one shared pipelined Q10 multiplier
// Optional build macro: MUL_Q10_SAT_EN clamps results to the signed DATA_WIDTH range instead of wrapping.

module mul_q10_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PIPE_STAGES = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 10
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] RND_BIAS = (PW'(1) << FRAC_BITS) - PW'(1);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic          accept;

  // Search upward from the requester just past the last one granted.
  always_comb begin
    int cand;
    logic [IW-1:0] cand_idx;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IW'(cand);
      if (!gnt_any && req_valid[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  assign accept = reset_n && !stall && gnt_any;

  // One-hot grant; withheld during reset and stall.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Pointer moves only when a transfer actually happens.
  always_comb begin
    ptr_d = accept ? gnt_idx : ptr_q;
  end

  // Pointer register; reset leaves requester 0 as the first candidate.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q <= IW'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: operand capture
  // ---------------------------------------------------------------------------
  logic                  s0_v_q, s0_v_d;
  logic [IW-1:0]         s0_tag_q, s0_tag_d;
  logic [DATA_WIDTH-1:0] s0_a_q, s0_a_d;
  logic [DATA_WIDTH-1:0] s0_b_q, s0_b_d;

  // Capture the granted operands and their owner; everything holds while stalled.
  always_comb begin
    s0_v_d   = s0_v_q;
    s0_tag_d = s0_tag_q;
    s0_a_d   = s0_a_q;
    s0_b_d   = s0_b_q;
    if (!stall) begin
      s0_v_d = accept;
      if (accept) begin
        s0_tag_d = gnt_idx;
        s0_a_d   = req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        s0_b_d   = req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Stage 0 registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s0_v_q   <= 1'b0;
      s0_tag_q <= '0;
      s0_a_q   <= '0;
      s0_b_q   <= '0;
    end else begin
      s0_v_q   <= s0_v_d;
      s0_tag_q <= s0_tag_d;
      s0_a_q   <= s0_a_d;
      s0_b_q   <= s0_b_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply and dequantize
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0]  op_a_ext, op_b_ext;
  logic signed [PW-1:0]  prod, biased;
  logic [DATA_WIDTH-1:0] res_c;
`ifdef MUL_Q10_SAT_EN
  localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic signed [PW-1:0]  shifted;
`endif

  // Full signed product; negative values are biased so the arithmetic shift truncates toward zero.
  always_comb begin
    op_a_ext = {{DATA_WIDTH{s0_a_q[DATA_WIDTH-1]}}, s0_a_q};
    op_b_ext = {{DATA_WIDTH{s0_b_q[DATA_WIDTH-1]}}, s0_b_q};
    prod     = op_a_ext * op_b_ext;
    biased   = prod[PW-1] ? (prod + $signed(RND_BIAS)) : prod;
`ifdef MUL_Q10_SAT_EN
    shifted  = biased >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      res_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      res_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res_c = shifted[DATA_WIDTH-1:0];
    end
`else
    res_c    = DATA_WIDTH'(biased >>> FRAC_BITS);
`endif
  end

  // ---------------------------------------------------------------------------
  // Result stages and output
  // ---------------------------------------------------------------------------
  logic          last_v;
  logic [IW-1:0] last_tag;
  logic          stage_busy;

  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign last_v     = s0_v_q;
      assign last_tag   = s0_tag_q;
      assign rsp_data   = res_c;
      assign stage_busy = 1'b0;
    end else begin : g_stages
      localparam int RS = PIPE_STAGES - 1;
      logic [RS-1:0]         v_q, v_d;
      logic [IW-1:0]         tag_q [RS];
      logic [IW-1:0]         tag_d [RS];
      logic [DATA_WIDTH-1:0] res_q [RS];
      logic [DATA_WIDTH-1:0] res_d [RS];

      // Shift entries one stage per unstalled cycle; data follows only valid entries so rsp_data keeps its last result.
      always_comb begin
        v_d   = v_q;
        tag_d = tag_q;
        res_d = res_q;
        if (!stall) begin
          v_d[0] = s0_v_q;
          if (s0_v_q) begin
            tag_d[0] = s0_tag_q;
            res_d[0] = res_c;
          end
          for (int k = 1; k < RS; k++) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
              tag_d[k] = tag_q[k-1];
              res_d[k] = res_q[k-1];
            end
          end
        end
      end

      // Result stage registers; reset drops any in-flight work.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          v_q <= '0;
          for (int k = 0; k < RS; k++) begin
            tag_q[k] <= '0;
            res_q[k] <= '0;
          end
        end else begin
          v_q   <= v_d;
          tag_q <= tag_d;
          res_q <= res_d;
        end
      end

      assign last_v     = v_q[RS-1];
      assign last_tag   = tag_q[RS-1];
      assign rsp_data   = res_q[RS-1];
      assign stage_busy = |v_q;
    end
  endgenerate

  // Route the finished entry back to its owner; suppressed while stalled so it is presented exactly once.
  always_comb begin
    rsp_valid = '0;
    if (last_v && !stall) begin
      rsp_valid[last_tag] = 1'b1;
    end
  end

  assign busy = s0_v_q | stage_busy;

endmodule

// File: tb/tb_mul_q10_arbiter.sv
// tb/tb_mul_q10_arbiter.sv - scoreboard testbench for mul_q10_arbiter

module tb_mul_q10_arbiter;

  localparam int N  = 4;
  localparam int P  = 2;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            stall = 1'b0;
  logic [N-1:0]    req_valid = '1;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          tag;
    logic [31:0] data;
    int          c;
  } exp_t;

  exp_t q[$];
  int   cnt = 0;
  int   rr_last = N - 1;
  int   rsp_count = 0;

  always #5 clock = ~clock;

  mul_q10_arbiter #(
    .NUM_REQ(N),
    .PIPE_STAGES(P),
    .DATA_WIDTH(DW),
    .FRAC_BITS(10)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .stall(stall),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .busy(busy)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Q10 product, truncated toward zero by integer division, then wrapped or clamped.
  function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b);
    longint p, r;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p / 1024;
`ifdef MUL_Q10_SAT_EN
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    else if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
    return r[31:0];
  endfunction

  function automatic int model_grant(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rnd_op();
    int v;
    case ($urandom_range(0, 3))
      0: return $urandom();
      1: begin
        v = int'($urandom_range(0, 8191)) - 4096;
        return v;
      end
      2: return $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: begin
        v = int'($urandom_range(0, 2000000)) - 1000000;
        return v;
      end
    endcase
  endfunction

  always @(posedge clock) begin
    if (!stall) cnt++;
  end

  // Monitor: predicts grants, queues expected results, checks responses as they appear.
  always @(negedge clock) begin : mon
    exp_t e;
    int g;
    logic [N-1:0] er;
    if (!reset_n) begin
      check("ready_in_reset", req_ready, 0);
      q.delete();
      rr_last = N - 1;
    end else begin
      if (stall) begin
        check("rsp_in_stall", rsp_valid, 0);
      end else if (rsp_valid != 0) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          e = q.pop_front();
          check("rsp_tag", rsp_valid, 1 << e.tag);
          check("rsp_data", rsp_data, e.data);
          check("rsp_latency", cnt - e.c, P - 1);
          rsp_count++;
        end
      end
      g  = stall ? -1 : model_grant(req_valid, rr_last);
      er = (g < 0) ? '0 : N'(1 << g);
      check("grant", req_ready, er);
      if (g >= 0) begin
        q.push_back('{g, ref_mul(req_a[g*DW +: DW], req_b[g*DW +: DW]), cnt + 1});
        rr_last = g;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(int i, logic [31:0] a, logic [31:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic step_release();
    logic [N-1:0] g;
    @(negedge clock);
    g = req_ready & req_valid;
    @(posedge clock);
    #1;
    req_valid = req_valid & ~g;
  endtask

  task automatic send(int i, logic [31:0] a, logic [31:0] b);
    set_op(i, a, b);
    req_valid[i] = 1'b1;
    for (int t = 0; t < 40 && req_valid[i]; t++) step_release();
    if (req_valid[i]) begin
      check("send_timeout", 1, 0);
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic expect_rsp(string name, int tag, logic [31:0] d);
    bit seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clock);
      if (rsp_valid != 0 && !stall) begin
        seen = 1'b1;
        check({name, "_tag"}, rsp_valid, 1 << tag);
        check({name, "_data"}, rsp_data, d);
      end
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    stall     = 1'b0;
    req_valid = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    stall     = 1'b0;
    for (int t = 0; t < 20 && (busy || q.size() != 0); t++) step();
    check("drain_empty", q.size(), 0);
    check("drain_idle", busy, 0);
  endtask

  initial begin
    int gi;
    int n0;

    // Reset state, with all requesters asserting valid during reset.
    step();
    step();
    reset_n   = 1'b1;
    req_valid = '0;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_busy", busy, 0);

    // Directed arithmetic cases.
    send(0, 32'h0000_0600, 32'h0000_0800);
    expect_rsp("mul_pos", 0, 32'h0000_0C00);
    send(0, 32'hFFFF_FA00, 32'h0000_0800);
    expect_rsp("mul_neg", 0, 32'hFFFF_F400);
    send(0, 32'hFFFF_FFFF, 32'h0000_0001);
    expect_rsp("round_neg", 0, 32'h0000_0000);
    send(0, 32'h0000_03FF, 32'h0000_0001);
    expect_rsp("round_pos", 0, 32'h0000_0000);
    send(0, 32'h7FFF_FFFF, 32'h0000_0800);
`ifdef MUL_Q10_SAT_EN
    expect_rsp("ovf_pos", 0, 32'h7FFF_FFFF);
`else
    expect_rsp("ovf_pos", 0, 32'hFFFF_FFFE);
`endif
    send(0, 32'h8000_0000, 32'h0000_0800);
`ifdef MUL_Q10_SAT_EN
    expect_rsp("ovf_neg", 0, 32'h8000_0000);
`else
    expect_rsp("ovf_neg", 0, 32'h0000_0000);
`endif
    drain();

    // Round-robin with every requester held valid.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, rnd_op(), rnd_op());
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      gi = onehot_idx(req_ready);
      check("rr_order", gi, k % N);
      @(posedge clock);
      #1;
      if (gi >= 0) set_op(gi, rnd_op(), rnd_op());
      check("rr_busy", busy, 1);
    end
    drain();

    // Stall with two operations in flight and a third requester waiting.
    n0 = rsp_count;
    set_op(1, rnd_op(), rnd_op());
    set_op(3, rnd_op(), rnd_op());
    req_valid = 4'b1010;
    step_release();
    step_release();
    stall = 1'b1;
    set_op(0, rnd_op(), rnd_op());
    req_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_busy", busy, 1);
    end
    stall = 1'b0;
    for (int t = 0; t < 10 && req_valid != 0; t++) step_release();
    drain();
    check("stall_rsp_count", rsp_count - n0, 3);

    // Randomized traffic with random stalls.
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_op(i, rnd_op(), rnd_op());
          req_valid[i] = 1'b1;
        end
      end
      step_release();
    end
    drain();

    // Reset with work in flight: nothing may come back, and requester 0 wins first.
    set_op(0, rnd_op(), rnd_op());
    set_op(1, rnd_op(), rnd_op());
    req_valid = 4'b0011;
    step_release();
    step_release();
    reset_n   = 1'b0;
    req_valid = '0;
    step();
    reset_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    for (int k = 0; k < 4; k++) step();
    check("midrst_busy_later", busy, 0);
    set_op(0, rnd_op(), rnd_op());
    set_op(2, rnd_op(), rnd_op());
    req_valid = 4'b0101;
    #1;
    check("midrst_first_grant", req_ready, 4'b0001);
    for (int t = 0; t < 10 && req_valid != 0; t++) step_release();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
